spectral_centroid_acc: RTL and testbench
========================================

Name: spectral_centroid_acc

Overview:
- Post-FFT accumulator that sits directly upstream of the fixed-point divider in postprocess.
- Consumes one magnitude beat per FFT bin per frame.
- Forms numerator A = sum(k*|X_k|) and denominator B = sum(|X_k|) in Q29.3.
- Presents the pair on a valid/ready output; the divider computes the spectral centroid as A/B.

Parameters:
- W_MAG, 24: unsigned magnitude width, format Q(W_MAG-3).3.
- N_BINS, 1024: maximum bins per frame (power of two, >= 4).
- W_INTEGER_O, 29: integer bits of outputs a, b.
- W_FRACTIONAL_O, 3: fractional bits of outputs a, b. Must equal 3, the magnitude fraction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  magnitude beat valid.
- s_ready  out  1  block accepts beat.
- s_mag  in  W_MAG  unsigned magnitude of current bin, Q.3.
- s_last  in  1  final bin of frame.
- m_valid  out  1  result pair valid.
- m_ready  in  1  divider/consumer accepts pair.
- a  out  32  signed numerator, Q29.3, always >= 0.
- b  out  32  signed denominator, Q29.3, always >= 0.
- m_len  out  clog2(N_BINS)+1  number of bins accumulated in frame.
- m_sat  out  1  a or b saturated.
- m_zero  out  1  b == 0; divider result invalid.
- m_ovf  out  1  frame forcibly closed at N_BINS without s_last.

Behaviour:
- Interface: one clock; reset is synchronous and active-low, named clk and rst_n.
- Reset values (rst_n==0 at a rising edge):
  - state=ACCUM, bin counter k=0, accumulators=0, product register empty.
  - s_ready=1, m_valid=0, a=b=0, m_len=0, m_sat=m_zero=m_ovf=0.
- Reset mid-frame or mid-OUT discards all partial or pending data. No output is produced for that frame.
- Beat handshake: accepted when s_valid && s_ready. s_ready is registered-state-derived only, never combinational from s_valid.
- States:
  - ACCUM: s_ready=1.
    - Each accepted beat registers product k*s_mag and s_mag (stage 1).
    - The previous stage-1 contents add into acc_a and acc_b.
    - k increments.
    - An accepted beat with s_last=1, or with k==N_BINS-1, goes to FLUSH.
    - m_ovf is set if the close was forced by k==N_BINS-1 with s_last=0.
  - FLUSH (1 cycle): s_ready=0. The final stage-1 product is added. Go to OUT.
  - OUT: m_valid=1, s_ready=0.
    - a, b, m_len and flags are registered on entry and held stable until m_ready.
    - On m_valid && m_ready: clear accumulators and k, go to ACCUM. s_ready=1 the next cycle.
- Latency: last beat accepted at edge T → m_valid=1 after edge T+2. Minimum frame-to-frame gap is 2 dead cycles plus OUT dwell.
- Gaps in s_valid inside a frame are allowed. Stage 1 holds a beat until the next accepted beat or FLUSH; no bins are lost or double-counted.
- Arithmetic:
  - k is clog2(N_BINS) bits.
  - Product is W_MAG+clog2(N_BINS) bits.
  - acc_b is W_MAG+clog2(N_BINS) bits; acc_a is W_MAG+2*clog2(N_BINS) bits. Both unsigned, non-wrapping.
  - Fraction is unchanged (3 bits), so a = acc_a and b = acc_b when each is <= 2^31-1.
  - Otherwise the saturating output is 2^31-1 and m_sat=1.
- m_zero=1 iff acc_b==0 (a is then also 0).
- m_len = bins accepted in the frame, 1..N_BINS.
- s_last on the forced-close beat (k==N_BINS-1): frame closes normally, m_ovf=0.
- Beats arriving after a forced close start a new frame at k=0.

Test Plan:
- N_BINS=4, mags 8,8,8,8 (1.0 each), s_last on 4th, m_ready=1 → a=48 (6.0), b=32 (4.0), m_len=4, flags 0. m_valid 2 cycles after last handshake and high for 1 cycle.
- Same frame with s_valid toggling 1/0 every cycle → identical a=48, b=32. Then hold m_ready=0 for 10 cycles → a/b/m_valid stable, s_ready=0 throughout. s_ready=1 the cycle after the m_ready handshake.
- All-zero frame of 4 bins → a=0, b=0, m_zero=1, m_sat=0.
- N_BINS=1024, 1024 beats of s_mag=2^24-1 → b=a=2^31-1, m_sat=1, m_len=1024.
- N_BINS=8, 10 beats of mag 8, no s_last:
  - First frame closes at beat 8: a=224, b=64, m_ovf=1.
  - Remaining 2 beats plus s_last on the 2nd → second frame a=8, b=16, m_len=2, m_ovf=0.
- rst_n=0 for one cycle after 2 beats of a 4-bin frame, then a clean frame of 8,8,8,8 → exactly one output a=48, b=32. No residue from the aborted frame.

Source files
------------

// File: rtl/spectral_centroid_acc.sv
// spectral_centroid_acc: builds the centroid numerator A = sum(k*|X_k|) and
// denominator B = sum(|X_k|) over one FFT frame. The pair is then presented
// to the downstream divider over a valid/ready handshake.
module spectral_centroid_acc #(
    parameter int W_MAG          = 24,
    parameter int N_BINS         = 1024,
    parameter int W_INTEGER_O    = 29,
    parameter int W_FRACTIONAL_O = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [W_MAG-1:0]              s_mag,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [W_INTEGER_O+W_FRACTIONAL_O-1:0] a,
    output logic [W_INTEGER_O+W_FRACTIONAL_O-1:0] b,
    output logic [$clog2(N_BINS):0]       m_len,
    output logic                          m_sat,
    output logic                          m_zero,
    output logic                          m_ovf
);

    localparam int KW = $clog2(N_BINS);
    localparam int PW = W_MAG + KW;
    localparam int AW = W_MAG + 2*KW;
    localparam int WO = W_INTEGER_O + W_FRACTIONAL_O;

    localparam logic [KW-1:0] K_LAST  = KW'(N_BINS - 1);
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [KW:0]   LEN_ONE = (KW+1)'(1);
    localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};

    // LATCH is a single internal cycle in which the final sums are saturated
    // and captured into the output registers before OUT is entered.
    typedef enum logic [1:0] {ACCUM, FLUSH, LATCH, OUT} state_t;

    state_t          state, next_state;
    logic [KW-1:0]   k;
    logic [PW-1:0]   prod_q;
    logic [W_MAG-1:0] mag_q;
    logic            s1_full;
    logic [AW-1:0]   acc_a;
    logic [PW-1:0]   acc_b;
    logic [KW:0]     len_q;
    logic            ovf_q;

    logic            accept;
    logic            close;
    logic [63:0]     ext_a;
    logic [63:0]     ext_b;
    logic            sat_a;
    logic            sat_b;

    // Handshake decode and next-state logic; s_ready depends on state only.
    always_comb begin
        next_state = state;
        s_ready    = (state == ACCUM);
        m_valid    = (state == OUT);
        accept     = s_valid && (state == ACCUM);
        close      = accept && (s_last || (k == K_LAST));
        case (state)
            ACCUM:   if (close) next_state = FLUSH;
            FLUSH:   next_state = LATCH;
            LATCH:   next_state = OUT;
            OUT:     if (m_ready) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // Saturation compare of both sums against the largest positive output.
    always_comb begin
        ext_a = 64'(acc_a);
        ext_b = 64'(acc_b);
        sat_a = (ext_a > 64'(OUT_MAX));
        sat_b = (ext_b > 64'(OUT_MAX));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= next_state;
    end

    // Two-stage accumulate datapath: stage 1 holds k*mag and mag, and the
    // previous stage-1 contents fold into the accumulators on the next beat or in FLUSH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k       <= '0;
            prod_q  <= '0;
            mag_q   <= '0;
            s1_full <= 1'b0;
            acc_a   <= '0;
            acc_b   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            a       <= '0;
            b       <= '0;
            m_len   <= '0;
            m_sat   <= 1'b0;
            m_zero  <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        prod_q  <= PW'(k) * PW'(s_mag);
                        mag_q   <= s_mag;
                        s1_full <= 1'b1;
                        if (s1_full) begin
                            acc_a <= acc_a + AW'(prod_q);
                            acc_b <= acc_b + PW'(mag_q);
                        end
                        k <= k + K_ONE;
                        if (close) begin
                            len_q <= {1'b0, k} + LEN_ONE;
                            ovf_q <= !s_last;
                        end
                    end
                end
                FLUSH: begin
                    if (s1_full) begin
                        acc_a <= acc_a + AW'(prod_q);
                        acc_b <= acc_b + PW'(mag_q);
                    end
                    s1_full <= 1'b0;
                end
                LATCH: begin
                    a      <= sat_a ? OUT_MAX : ext_a[WO-1:0];
                    b      <= sat_b ? OUT_MAX : ext_b[WO-1:0];
                    m_sat  <= sat_a || sat_b;
                    m_zero <= (acc_b == '0);
                    m_len  <= len_q;
                    m_ovf  <= ovf_q;
                end
                OUT: begin
                    if (m_ready) begin
                        acc_a   <= '0;
                        acc_b   <= '0;
                        k       <= '0;
                        s1_full <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spectral_centroid_acc.sv
// tb_spectral_centroid_acc: directed and randomized frames against a small
// arithmetic model of the centroid sums, on an 8-bin and a 1024-bin instance.
module tb_spectral_centroid_acc;

    logic        clk;
    logic        rst_n;
    logic        s_valid, s_ready, s_last, m_valid, m_ready;
    logic [23:0] s_mag;
    logic [31:0] a, b;
    logic [3:0]  m_len;
    logic        m_sat, m_zero, m_ovf;

    logic        s_valid2, s_ready2, s_last2, m_valid2, m_ready2;
    logic [23:0] s_mag2;
    logic [31:0] a2, b2;
    logic [10:0] m_len2;
    logic        m_sat2, m_zero2, m_ovf2;

    int checks = 0;
    int errors = 0;

    int     magBuf [0:7];
    longint expA, expB;
    int     expLen;
    bit     expSat, expZero, expOvf;

    spectral_centroid_acc #(.W_MAG(24), .N_BINS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_mag(s_mag), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .a(a), .b(b), .m_len(m_len), .m_sat(m_sat), .m_zero(m_zero), .m_ovf(m_ovf)
    );

    spectral_centroid_acc #(.W_MAG(24), .N_BINS(1024)) dut1024 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_mag(s_mag2), .s_last(s_last2), .m_valid(m_valid2), .m_ready(m_ready2),
        .a(a2), .b(b2), .m_len(m_len2), .m_sat(m_sat2), .m_zero(m_zero2), .m_ovf(m_ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: centroid sums straight from the definition, then clamp.
    task automatic modelFrame(input int n, input bit forced);
        longint sa = 0, sb = 0;
        for (int i = 0; i < n; i++) begin
            sa += longint'(i) * magBuf[i];
            sb += magBuf[i];
        end
        expSat  = (sa > 64'h7FFF_FFFF) || (sb > 64'h7FFF_FFFF);
        expA    = (sa > 64'h7FFF_FFFF) ? 64'h7FFF_FFFF : sa;
        expB    = (sb > 64'h7FFF_FFFF) ? 64'h7FFF_FFFF : sb;
        expZero = (sb == 0);
        expLen  = n;
        expOvf  = forced;
    endtask

    // Present one beat at a negedge and hold it until the DUT takes it.
    task automatic applyStimulus(input int mag, input bit last);
        int t = 0;
        s_valid = 1'b1;
        s_mag   = 24'(mag);
        s_last  = last;
        while (!s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) checkOutput("beat_accept_timeout", 64'(t), 64'd0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Drive a frame from magBuf, then check latency, result and hold behaviour.
    task automatic runFrame(input int n, input bit useLast, input bit gaps, input int hold);
        int lat = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) @(negedge clk);
            applyStimulus(magBuf[i], useLast && (i == n-1));
        end
        modelFrame(n, !useLast && (n == 8));
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'd2);
        checkOutput("a", 64'(a), 64'(expA));
        checkOutput("b", 64'(b), 64'(expB));
        checkOutput("m_len", 64'(m_len), 64'(expLen));
        checkOutput("m_sat", 64'(m_sat), 64'(expSat));
        checkOutput("m_zero", 64'(m_zero), 64'(expZero));
        checkOutput("m_ovf", 64'(m_ovf), 64'(expOvf));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(m_valid), 64'd1);
            checkOutput("hold_a", 64'(a), 64'(expA));
            checkOutput("hold_b", 64'(b), 64'(expB));
            checkOutput("hold_s_ready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checkOutput("valid_drop", 64'(m_valid), 64'd0);
        checkOutput("ready_return", 64'(s_ready), 64'd1);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; s_valid = 1'b0; s_mag = '0; s_last = 1'b0; m_ready = 1'b0;
        s_valid2 = 1'b0; s_mag2 = '0; s_last2 = 1'b0; m_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_s_ready", 64'(s_ready), 64'd1);
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_a", 64'(a), 64'd0);
        checkOutput("rst_b", 64'(b), 64'd0);
        checkOutput("rst_m_len", 64'(m_len), 64'd0);
        checkOutput("rst_flags", 64'({m_sat, m_zero, m_ovf}), 64'd0);

        $display("[TB] unit magnitudes, contiguous then gapped with held m_ready");
        for (int i = 0; i < 8; i++) magBuf[i] = 8;
        runFrame(4, 1'b1, 1'b0, 0);
        checkOutput("unit_a", 64'(expA), 64'd48);
        checkOutput("unit_b", 64'(expB), 64'd32);
        runFrame(4, 1'b1, 1'b1, 10);

        $display("[TB] all-zero frame");
        for (int i = 0; i < 8; i++) magBuf[i] = 0;
        runFrame(4, 1'b1, 1'b0, 0);

        $display("[TB] forced close at 8 bins then 2-bin remainder");
        for (int i = 0; i < 8; i++) magBuf[i] = 8;
        runFrame(8, 1'b0, 1'b0, 0);
        checkOutput("ovf_a", 64'(expA), 64'd224);
        runFrame(2, 1'b1, 1'b0, 0);
        checkOutput("rem_a", 64'(expA), 64'd8);

        $display("[TB] s_last on the eighth bin");
        runFrame(8, 1'b1, 1'b0, 0);

        $display("[TB] reset in mid-frame");
        applyStimulus(100, 1'b0);
        applyStimulus(200, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_s_ready", 64'(s_ready), 64'd1);
        checkOutput("midrst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("midrst_a", 64'(a), 64'd0);
        for (int i = 0; i < 8; i++) magBuf[i] = 8;
        runFrame(4, 1'b1, 1'b0, 0);
        t = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid) t++;
        end
        checkOutput("no_residue", 64'(t), 64'd0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 16; f++) begin
            int  n;
            bit  useLast;
            n = $urandom_range(1, 8);
            useLast = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0:       magBuf[i] = 0;
                    1:       magBuf[i] = $urandom_range(0, 255);
                    default: magBuf[i] = int'($urandom_range(0, 24'hFF_FFFF));
                endcase
            end
            runFrame(n, useLast, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("[TB] 1024 full-scale bins, saturation");
        checkOutput("big_s_ready", 64'(s_ready2), 64'd1);
        s_valid2 = 1'b1;
        s_mag2   = 24'hFF_FFFF;
        for (int i = 0; i < 1024; i++) begin
            s_last2 = (i == 1023);
            @(negedge clk);
        end
        s_valid2 = 1'b0;
        s_last2  = 1'b0;
        t = 0;
        while (!m_valid2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("big_latency", 64'(t), 64'd2);
        checkOutput("big_a", 64'(a2), 64'h7FFF_FFFF);
        checkOutput("big_b", 64'(b2), 64'h7FFF_FFFF);
        checkOutput("big_m_sat", 64'(m_sat2), 64'd1);
        checkOutput("big_m_len", 64'(m_len2), 64'd1024);
        checkOutput("big_m_ovf", 64'(m_ovf2), 64'd0);
        checkOutput("big_m_zero", 64'(m_zero2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
